ssb_sync_ctrl: RTL and testbench
================================

SSB_SYNC_CTRL -- requirements
Module: ssb_sync_ctrl

Interface
REQ-001 SHALL have parameter SSB_PERIOD, default 76800, meaning the expected PSS spacing in valid input samples.
REQ-002 SHALL have parameter WINDOW, default 8, meaning the ± tolerance in samples around the expected PSS position.
REQ-003 SHALL have parameter MAX_MISSES, default 3, meaning the number of consecutive missed PSS before lock is lost.
REQ-004 SHALL have parameter SSS_TIMEOUT, default 4096, meaning the clock cycles allowed for N_id_1 after a PSS in search.
REQ-005 SHALL have ports, one per line, as follows.
- clk_i, in, 1: single clock.
- reset_ni, in, 1: synchronous, active-low reset.
- sample_valid_i, in, 1: decimated sample strobe.
- N_id_2_valid_i, in, 1: PSS detector peak pulse.
- N_id_2_i, in, 2: detected N_id_2.
- N_id_1_valid_i, in, 1: SSS detector result pulse.
- N_id_1_i, in, 9: detected N_id_1.
- force_search_i, in, 1: restart the search.
- PSS_detector_mode_o, out, 2: 0 = search all, 1 = requested N_id_2 only.
- requested_N_id_2_o, out, 2: N_id_2 the detector tracks.
- N_id_o, out, 10: cell ID.
- N_id_valid_o, out, 1: one-cycle pulse.
- locked_o, out, 1: high in TRACK.
- ssb_start_o, out, 1: one-cycle pulse on each accepted PSS.
- sync_lost_o, out, 1: one-cycle pulse.
- state_o, out, 2: debug state.

Function
REQ-006 SHALL implement states SEARCH=0, WAIT_SSS=1, TRACK=2; all outputs registered.
REQ-007 SEARCH behaviour:
- mode_o=0.
- On N_id_2_valid_i: latch N_id_2_i into requested_N_id_2_o, clear the timeout counter, pulse ssb_start_o, go to WAIT_SSS.
REQ-008 WAIT_SSS behaviour:
- mode_o=0; the timeout counter increments every clock.
- N_id_2_valid_i is ignored.
REQ-009 WAIT_SSS exits:
- On N_id_1_valid_i with N_id_1_i<=335: N_id_o=3*N_id_1_i+requested_N_id_2_o (exact, 10 bits); pulse N_id_valid_o; clear the sample counter and miss counter; go to TRACK.
- N_id_1_valid_i with N_id_1_i>335 is ignored.
- Counter reaching SSS_TIMEOUT-1 without a valid N_id_1: go to SEARCH.
- Valid N_id_1 on the same cycle as timeout: N_id_1 wins.
REQ-010 TRACK behaviour:
- mode_o=1; locked_o=1.
- The sample counter increments on each sample_valid_i.
REQ-011 TRACK acceptance:
- N_id_2_valid_i with counter in [SSB_PERIOD-WINDOW, SSB_PERIOD+WINDOW] is accepted: counter becomes 0 (1 if sample_valid_i is also high), miss counter clears, ssb_start_o pulses.
- Detections outside the window are ignored.
REQ-012 TRACK miss handling:
- Counter reaching SSB_PERIOD+WINDOW with sample_valid_i and no accepted detection is a miss: counter becomes WINDOW+1 and miss counter increments.
- A detection on that same cycle is accepted, not a miss.
REQ-013 TRACK loss of lock:
- The miss that makes miss count equal MAX_MISSES goes to SEARCH, pulses sync_lost_o, and deasserts locked_o.
- N_id_o holds its last value.
REQ-014 force_search_i in any state SHALL go to SEARCH next cycle and clear all counters.
- It has priority over all other events.
- It pulses sync_lost_o only if the block was in TRACK.
REQ-015 Counter widths SHALL be $clog2 of (SSB_PERIOD+WINDOW+1), SSS_TIMEOUT and MAX_MISSES+1; no wrap-around is reachable.
REQ-016 Pulse outputs SHALL be high for exactly one cycle per event.

Reset
REQ-017 While reset_ni=0 at a clock edge, the block SHALL enter the following state:
- state SEARCH.
- mode_o=0, requested_N_id_2_o=0.
- N_id_o=0, N_id_valid_o=0, locked_o=0.
- ssb_start_o=0, sync_lost_o=0.
- All counters 0.
REQ-018 Reset asserted mid-operation SHALL abort any state within one cycle; no pulse is emitted on the reset cycle.

Verification (SSB_PERIOD=100, WINDOW=4, MAX_MISSES=2, SSS_TIMEOUT=50, sample_valid_i=1)
REQ-019 Acquire:
- Stimulus: N_id_2=2 pulse, then N_id_1=100 valid 10 cycles later.
- Response: N_id_o=302, N_id_valid_o one pulse, locked_o=1, mode_o=1, requested_N_id_2_o=2.
REQ-020 SSS timeout:
- Stimulus: PSS pulse, no N_id_1 for 50 cycles.
- Response: state_o returns to 0, locked_o=0, no N_id_valid_o.
REQ-021 Tracking window:
- Stimulus: in TRACK, PSS at counter 96, then 104, then 90.
- Response: first two accepted with ssb_start_o; third ignored.
REQ-022 Loss of lock:
- Stimulus: two consecutive periods without PSS.
- Response: sync_lost_o pulses at the second counter=104, state SEARCH, N_id_o unchanged.
REQ-023 Priority:
- Stimulus: force_search_i on the same cycle as an in-window PSS.
- Response: SEARCH next cycle, no ssb_start_o.
- Stimulus: reset mid-WAIT_SSS.
- Response: all outputs at reset values.

Source files
------------

// File: rtl/ssb_sync_ctrl.sv
// SSB timing controller: acquires PSS/SSS to form the cell ID, then tracks
// the PSS period inside a tolerance window and drops lock after repeated misses.
module ssb_sync_ctrl #(
  parameter int SSB_PERIOD  = 76800,
  parameter int WINDOW      = 8,
  parameter int MAX_MISSES  = 3,
  parameter int SSS_TIMEOUT = 4096
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       sample_valid_i,
  input  logic       N_id_2_valid_i,
  input  logic [1:0] N_id_2_i,
  input  logic       N_id_1_valid_i,
  input  logic [8:0] N_id_1_i,
  input  logic       force_search_i,
  output logic [1:0] PSS_detector_mode_o,
  output logic [1:0] requested_N_id_2_o,
  output logic [9:0] N_id_o,
  output logic       N_id_valid_o,
  output logic       locked_o,
  output logic       ssb_start_o,
  output logic       sync_lost_o,
  output logic [1:0] state_o
);

  localparam int SW_RAW = $clog2(SSB_PERIOD + WINDOW + 1);
  localparam int TW_RAW = $clog2(SSS_TIMEOUT);
  localparam int MW_RAW = $clog2(MAX_MISSES + 1);
  localparam int SW = (SW_RAW < 1) ? 1 : SW_RAW;
  localparam int TW = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam int MW = (MW_RAW < 1) ? 1 : MW_RAW;

  localparam logic [SW-1:0] WIN_LO   = SW'(SSB_PERIOD - WINDOW);
  localparam logic [SW-1:0] WIN_HI   = SW'(SSB_PERIOD + WINDOW);
  localparam logic [SW-1:0] MISS_RST = SW'(WINDOW + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(SSS_TIMEOUT - 1);
  localparam logic [MW-1:0] MISS_MAX = MW'(MAX_MISSES);

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    WAIT_SSS = 2'd1,
    TRACK    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    req_q, req_d;
  logic [9:0]    nid_q, nid_d;
  logic          nid_vld_q, nid_vld_d;
  logic          locked_q, locked_d;
  logic          ssb_start_q, ssb_start_d;
  logic          sync_lost_q, sync_lost_d;
  logic [SW-1:0] smp_cnt_q, smp_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [MW-1:0] miss_q, miss_d;

  logic [9:0] n1_ext;
  logic [9:0] nid_calc;
  logic       n1_ok;
  logic       in_win;

  assign n1_ext   = {1'b0, N_id_1_i};
  assign nid_calc = (n1_ext << 1) + n1_ext + {8'b0, req_q};
  assign n1_ok    = N_id_1_valid_i && (N_id_1_i <= 9'd335);
  assign in_win   = (smp_cnt_q >= WIN_LO) && (smp_cnt_q <= WIN_HI);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    req_d       = req_q;
    nid_d       = nid_q;
    nid_vld_d   = 1'b0;
    locked_d    = locked_q;
    ssb_start_d = 1'b0;
    sync_lost_d = 1'b0;
    smp_cnt_d   = smp_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    miss_d      = miss_q;

    if (force_search_i) begin
      state_d     = SEARCH;
      mode_d      = 2'd0;
      locked_d    = 1'b0;
      sync_lost_d = (state_q == TRACK);
      smp_cnt_d   = '0;
      tmo_cnt_d   = '0;
      miss_d      = '0;
    end else begin
      case (state_q)
        SEARCH: begin
          mode_d   = 2'd0;
          locked_d = 1'b0;
          if (N_id_2_valid_i) begin
            req_d       = N_id_2_i;
            tmo_cnt_d   = '0;
            ssb_start_d = 1'b1;
            state_d     = WAIT_SSS;
          end
        end
        WAIT_SSS: begin
          mode_d = 2'd0;
          // A valid SSS arriving on the timeout cycle still completes acquisition.
          if (n1_ok) begin
            nid_d     = nid_calc;
            nid_vld_d = 1'b1;
            smp_cnt_d = '0;
            miss_d    = '0;
            mode_d    = 2'd1;
            locked_d  = 1'b1;
            state_d   = TRACK;
          end else if (tmo_cnt_q == TMO_LAST) begin
            tmo_cnt_d = '0;
            state_d   = SEARCH;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
        TRACK: begin
          mode_d   = 2'd1;
          locked_d = 1'b1;
          if (N_id_2_valid_i && in_win) begin
            smp_cnt_d   = sample_valid_i ? SW'(1) : '0;
            miss_d      = '0;
            ssb_start_d = 1'b1;
          end else if (sample_valid_i && (smp_cnt_q == WIN_HI)) begin
            // Restart as if the PSS had landed at the nominal position.
            if (miss_q + 1'b1 == MISS_MAX) begin
              state_d     = SEARCH;
              mode_d      = 2'd0;
              locked_d    = 1'b0;
              sync_lost_d = 1'b1;
              smp_cnt_d   = '0;
              miss_d      = '0;
            end else begin
              smp_cnt_d = MISS_RST;
              miss_d    = miss_q + 1'b1;
            end
          end else if (sample_valid_i) begin
            smp_cnt_d = smp_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d  = SEARCH;
          mode_d   = 2'd0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= SEARCH;
      mode_q      <= 2'd0;
      req_q       <= 2'd0;
      nid_q       <= 10'd0;
      nid_vld_q   <= 1'b0;
      locked_q    <= 1'b0;
      ssb_start_q <= 1'b0;
      sync_lost_q <= 1'b0;
      smp_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      req_q       <= req_d;
      nid_q       <= nid_d;
      nid_vld_q   <= nid_vld_d;
      locked_q    <= locked_d;
      ssb_start_q <= ssb_start_d;
      sync_lost_q <= sync_lost_d;
      smp_cnt_q   <= smp_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      miss_q      <= miss_d;
    end
  end

  assign PSS_detector_mode_o = mode_q;
  assign requested_N_id_2_o  = req_q;
  assign N_id_o              = nid_q;
  assign N_id_valid_o        = nid_vld_q;
  assign locked_o            = locked_q;
  assign ssb_start_o         = ssb_start_q;
  assign sync_lost_o         = sync_lost_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_ssb_sync_ctrl.sv
// Directed bench for ssb_sync_ctrl with a short period (100), window 4,
// two misses to lose lock and a 50-cycle SSS timeout.
module tb_ssb_sync_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sample_valid;
  logic       n2_vld;
  logic [1:0] n2;
  logic       n1_vld;
  logic [8:0] n1;
  logic       force_search;
  logic [1:0] mode;
  logic [1:0] req_n2;
  logic [9:0] nid;
  logic       nid_vld;
  logic       locked;
  logic       ssb_start;
  logic       sync_lost;
  logic [1:0] state;

  int n_chk  = 0;
  int n_pass = 0;
  logic seen_vld;

  always #5 clk = ~clk;

  ssb_sync_ctrl #(
    .SSB_PERIOD (100),
    .WINDOW     (4),
    .MAX_MISSES (2),
    .SSS_TIMEOUT(50)
  ) dut (
    .clk_i              (clk),
    .reset_ni           (reset_n),
    .sample_valid_i     (sample_valid),
    .N_id_2_valid_i     (n2_vld),
    .N_id_2_i           (n2),
    .N_id_1_valid_i     (n1_vld),
    .N_id_1_i           (n1),
    .force_search_i     (force_search),
    .PSS_detector_mode_o(mode),
    .requested_N_id_2_o (req_n2),
    .N_id_o             (nid),
    .N_id_valid_o       (nid_vld),
    .locked_o           (locked),
    .ssb_start_o        (ssb_start),
    .sync_lost_o        (sync_lost),
    .state_o            (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Inputs set before a tick are sampled on its rising edge; outputs are read 1ns later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (nid_vld) seen_vld = 1'b1;
    end
  endtask

  task automatic pulse_pss(input logic [1:0] id2);
    n2_vld = 1'b1;
    n2     = id2;
    tick(1);
    n2_vld = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; sample_valid = 1'b1; n2_vld = 1'b0; n2 = 2'd0;
    n1_vld = 1'b0; n1 = 9'd0; force_search = 1'b0; seen_vld = 1'b0;
    tick(2);
    chk("rst_state", state, 0);
    chk("rst_mode", mode, 0);
    chk("rst_req", req_n2, 0);
    chk("rst_nid", nid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_pulses", {nid_vld, ssb_start, sync_lost}, 0);
    reset_n = 1'b1;
    tick(1);

    // Acquire: PSS N_id_2=2, SSS N_id_1=100 ten cycles later
    pulse_pss(2'd2);
    chk("acq_ssb_start", ssb_start, 1);
    chk("acq_state_wait", state, 1);
    chk("acq_req", req_n2, 2);
    tick(9);
    n1_vld = 1'b1; n1 = 9'd100;
    tick(1);
    n1_vld = 1'b0;
    chk("acq_nid", nid, 302);
    chk("acq_nid_vld", nid_vld, 1);
    chk("acq_state_track", state, 2);
    chk("acq_locked", locked, 1);
    chk("acq_mode", mode, 1);
    tick(1);
    chk("acq_nid_vld_1cyc", nid_vld, 0);

    // Tracking window: counter now 1
    tick(95);
    pulse_pss(2'd2);
    chk("trk_96_accept", ssb_start, 1);
    tick(1);
    chk("trk_start_1cyc", ssb_start, 0);
    tick(102);
    pulse_pss(2'd2);
    chk("trk_104_accept", ssb_start, 1);
    chk("trk_104_state", state, 2);
    tick(89);
    pulse_pss(2'd2);
    chk("trk_90_ignored", ssb_start, 0);
    chk("trk_90_state", state, 2);

    // Loss of lock: counter 91 -> first miss at 104, second 99 samples later
    tick(13);
    chk("miss1_no_lost", sync_lost, 0);
    tick(1);
    chk("miss1_state", state, 2);
    chk("miss1_locked", locked, 1);
    tick(99);
    chk("miss2_pre_state", state, 2);
    tick(1);
    chk("lost_pulse", sync_lost, 1);
    chk("lost_state", state, 0);
    chk("lost_locked", locked, 0);
    chk("lost_mode", mode, 0);
    chk("lost_nid_hold", nid, 302);
    tick(1);
    chk("lost_pulse_1cyc", sync_lost, 0);

    // SSS timeout, with an out-of-range N_id_1 and a PSS that must be ignored
    seen_vld = 1'b0;
    pulse_pss(2'd1);
    chk("to_state_wait", state, 1);
    tick(10);
    n1_vld = 1'b1; n1 = 9'd400;
    tick(1);
    n1_vld = 1'b0;
    n2_vld = 1'b1; n2 = 2'd3;
    tick(1);
    n2_vld = 1'b0;
    chk("to_req_kept", req_n2, 1);
    chk("to_ssb_ignored", ssb_start, 0);
    tick(37);
    chk("to_still_wait", state, 1);
    tick(1);
    chk("to_back_search", state, 0);
    chk("to_locked", locked, 0);
    chk("to_no_nid_vld", seen_vld, 0);

    // SSS on the timeout cycle wins; N_id_1=335 boundary
    pulse_pss(2'd0);
    tick(49);
    chk("tmo_edge_wait", state, 1);
    n1_vld = 1'b1; n1 = 9'd335;
    tick(1);
    n1_vld = 1'b0;
    chk("tmo_edge_track", state, 2);
    chk("tmo_edge_nid", nid, 1005);
    chk("tmo_edge_vld", nid_vld, 1);

    // force_search with in-window PSS
    tick(96);
    n2_vld = 1'b1; force_search = 1'b1;
    tick(1);
    n2_vld = 1'b0; force_search = 1'b0;
    chk("force_state", state, 0);
    chk("force_no_start", ssb_start, 0);
    chk("force_lost", sync_lost, 1);
    chk("force_locked", locked, 0);
    force_search = 1'b1;
    tick(1);
    force_search = 1'b0;
    chk("force_search_no_lost", sync_lost, 0);

    // Reset mid-WAIT_SSS, with a valid SSS on the reset edge
    pulse_pss(2'd3);
    chk("rst2_wait", state, 1);
    tick(5);
    reset_n = 1'b0; n1_vld = 1'b1; n1 = 9'd10;
    tick(1);
    n1_vld = 1'b0;
    chk("rst2_state", state, 0);
    chk("rst2_req", req_n2, 0);
    chk("rst2_nid", nid, 0);
    chk("rst2_mode", mode, 0);
    chk("rst2_locked", locked, 0);
    chk("rst2_pulses", {nid_vld, ssb_start, sync_lost}, 0);
    reset_n = 1'b1;
    tick(2);
    chk("rst2_idle", state, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
